spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Mode 0 (CPOL=0, CPHA=0) SPI master; the initiator end of the bus served by the team's SPI slave.
- Generates SCLK, CS_N and MOSI from the system clock and captures MISO.
- Serialises one DATA_WIDTH word per accepted request through a valid/ready handshake.
- Sits between the flight-controller internal logic and external SPI peripherals, and serves as the loopback driver for slave verification.

Parameters:
- DATA_WIDTH, 8, bits per word, MSB first.
- CLK_DIV, 4, i_clk cycles per SCLK half-period; legal minimum 2.
- CS_SETUP_CYC, 2, i_clk cycles from CS_N falling to the first SCLK rising; minimum 1.
- CS_HOLD_CYC, 2, i_clk cycles from the last SCLK falling to CS_N rising; minimum 1.
- CS_IDLE_CYC, 4, minimum i_clk cycles CS_N stays high between transactions; minimum 1.

Ports:
- i_clk  input  1  system clock; the only clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_tx_data  input  DATA_WIDTH  word to transmit.
- i_tx_valid  input  1  request to transmit i_tx_data.
- o_tx_ready  output  1  master can accept a request.
- o_rx_data  output  DATA_WIDTH  word captured from MISO.
- o_rx_valid  output  1  one-cycle pulse; o_rx_data is valid.
- o_busy  output  1  transaction in progress.
- o_sclk  output  1  SPI clock, idles low.
- o_cs_n  output  1  chip select, active low.
- o_mosi  output  1  master out.
- i_miso  input  1  master in.

Behaviour:
- Reset: async assert forces o_sclk=0, o_cs_n=1, o_mosi=0, o_busy=0, o_rx_valid=0, o_rx_data=0, o_tx_ready=0. FSM goes to IDLE.
- Reset mid-transfer aborts immediately. There is no o_rx_valid for the aborted word.
- All outputs are registered.
- FSM states:
  - IDLE: o_tx_ready=1. On i_tx_valid, latch i_tx_data into the shift register and go to SETUP. Accept cycle is T.
  - SETUP: from T+1, o_cs_n=0, o_busy=1, o_mosi=word MSB, o_sclk=0. Lasts CS_SETUP_CYC cycles, then go to HIGH.
  - HIGH: o_sclk=1 for CLK_DIV cycles.
    - On the final HIGH cycle's clock edge: shift i_miso into the rx shift register and drive o_sclk=0.
    - If bits remain: shift the next tx bit onto o_mosi on that same edge and go to LOW.
    - Otherwise go to HOLD.
    - Sampling late in the high phase gives margin for the slave's 2-FF synchronizer plus edge-detect latency (about 4 i_clk).
  - LOW: o_sclk=0 for CLK_DIV cycles, then go to HIGH.
  - HOLD: o_sclk=0 for CS_HOLD_CYC cycles.
    - o_rx_data updates and o_rx_valid pulses for exactly one cycle, in the first HOLD cycle.
    - Then o_cs_n=1 and go to GAP.
  - GAP: o_cs_n=1, o_mosi=0, lasts CS_IDLE_CYC cycles. o_busy drops and the FSM returns to IDLE at GAP end.
- o_tx_ready=1 only in IDLE. i_tx_valid outside IDLE is ignored; the requester must hold it.
- Exactly DATA_WIDTH rising edges occur per word, always with the low→high order; no partial words.
- Non-burst word period, from accept to next ready: 1 + CS_SETUP_CYC + (2·DATA_WIDTH−1)·CLK_DIV + CS_HOLD_CYC + CS_IDLE_CYC cycles.
- Bit counter is $clog2(DATA_WIDTH)+1 bits wide. The divider counter is $clog2(CLK_DIV) bits wide and wraps to 0 on every phase change.
- i_tx_data changes after acceptance do not affect the word in flight.

Optional Feature:
- Macro: SPI_MASTER_BURST_EN.
- Defined:
  - o_tx_ready also asserts during the final HIGH cycle of a word.
  - If i_tx_valid is high then, the new word is latched and its MSB is driven on o_mosi at that falling edge. The FSM goes to LOW with CS_N kept low; SETUP, HOLD and GAP are skipped.
  - o_rx_valid for the finished word pulses the cycle after that edge.
  - o_busy stays high throughout.
- Undefined: every word is a separate CS_N frame as described above; ready is in IDLE only.

Decomposition:
- Package spi_pkg holds:
  - typedef spi_master_state_t (IDLE, SETUP, LOW, HIGH, HOLD, GAP);
  - localparam SPI_MODE0_CPOL=0, SPI_MODE0_CPHA=0;
  - a shared DATA_WIDTH default of 8, common with the slave.
- One sub-module, spi_clk_div: a divider counter emitting a phase_end strobe with a synchronous restart. The shift/FSM logic stays in spi_master.

Test Plan:
- Loopback (o_mosi→i_miso), defaults, send 0xA5:
  - exactly 8 SCLK rising edges, each high phase 4 cycles;
  - o_cs_n low 2 cycles before the first rising edge and 2 cycles after the last falling edge;
  - o_rx_data=0xA5 with a single o_rx_valid pulse.
- Slave-model responder returning 0x3C, master sends 0xFF: o_rx_data=0x3C, and the MOSI bit sequence observed at rising edges is 1111_1111.
- Two requests presented back-to-back (burst off): CS_N high for ≥4 cycles between frames, o_tx_ready low during the frame, second word 0x01 received intact.
- i_tx_valid toggled with 0x55 while busy on 0xAA: request ignored, wire shows only 0xAA until o_tx_ready returns.
- Reset pulse during bit 4: same cycle o_cs_n=1, o_sclk=0, no o_rx_valid; the next 0x96 transfer after reset is correct.
- SPI_MASTER_BURST_EN defined, 0x12 then 0x34 queued:
  - CS_N stays low across 16 rising edges;
  - two o_rx_valid pulses (0x12, 0x34) in loopback;
  - the LOW phase between words is exactly 4 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by spi_master and its sub-modules.
//   spi_master_state_t : master FSM state encoding
//   SPI_MODE0_CPOL/CPHA: bus mode constants (mode 0)
//   SPI_DATA_WIDTH     : default word width, common with the SPI slave
//   spi_max3           : helper for sizing shared timers
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_master_state_t;

  localparam bit SPI_MODE0_CPOL = 1'b0;
  localparam bit SPI_MODE0_CPHA = 1'b0;

  localparam int unsigned SPI_DATA_WIDTH = 8;

  function automatic int unsigned spi_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK phase divider: counts i_clk cycles within one SCLK half-period.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_en           : count while an SCLK phase is active
//   i_restart      : synchronous clear of the count
//   o_cnt          : current position inside the phase (0..CLK_DIV-1)
//   o_phase_end    : high in the last i_clk cycle of a phase
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_restart,
  output logic [$clog2(CLK_DIV)-1:0] o_cnt,
  output logic                       o_phase_end
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last      = (r_cnt == CW'(CLK_DIV - 1));
  assign o_phase_end = i_en && !i_restart && w_last;
  assign o_cnt       = r_cnt;

  // Wraps to 0 at each phase end so HIGH and LOW phases start aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode 0 (CPOL=0, CPHA=0) SPI master, one DATA_WIDTH word per request, MSB first.
//   i_clk, i_rst_n          : system clock, async active-low reset
//   i_tx_data, i_tx_valid   : request word / request strobe
//   o_tx_ready              : request accepted when high together with i_tx_valid
//   o_rx_data, o_rx_valid   : captured MISO word, one-cycle valid pulse
//   o_busy                  : transaction in progress
//   o_sclk, o_cs_n, o_mosi  : SPI bus outputs (all registered)
//   i_miso                  : SPI bus input
// Build option: define SPI_MASTER_BURST_EN to chain words inside one CS_N frame.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = SPI_DATA_WIDTH,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 2,
  parameter int unsigned CS_IDLE_CYC  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_busy,
  output logic                  o_sclk,
  output logic                  o_cs_n,
  output logic                  o_mosi,
  input  logic                  i_miso
);

  localparam int unsigned CW   = $clog2(CLK_DIV);
  localparam int unsigned BW   = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned TMAX = spi_max3(CS_SETUP_CYC, CS_HOLD_CYC, CS_IDLE_CYC);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  spi_master_state_t     r_state;
  logic [DATA_WIDTH-2:0] r_tx_shift;  // bits still to send after the one on o_mosi
  logic [DATA_WIDTH-2:0] r_rx_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic [TW-1:0]         r_tmr;
  logic                  r_tx_ready;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_busy;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_mosi;

  logic                  w_div_en;
  logic                  w_phase_end;
  logic [CW-1:0]         w_div_cnt;
  logic                  w_last_bit;
  logic [DATA_WIDTH-1:0] w_rx_word;

  assign w_div_en   = (r_state == HIGH) || (r_state == LOW);
  assign w_last_bit = (r_bit_cnt == BW'(DATA_WIDTH - 1));
  assign w_rx_word  = {r_rx_shift, i_miso};

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (w_div_en),
    .i_restart   (!w_div_en),
    .o_cnt       (w_div_cnt),
    .o_phase_end (w_phase_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_tmr      <= '0;
      r_tx_ready <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_sclk     <= SPI_MODE0_CPOL;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_ready <= 1'b1;
          r_tmr      <= '0;
          if (i_tx_valid && r_tx_ready) begin
            r_tx_shift <= i_tx_data[DATA_WIDTH-2:0];
            r_mosi     <= i_tx_data[DATA_WIDTH-1];
            r_bit_cnt  <= '0;
            r_cs_n     <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_ready <= 1'b0;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          if (r_tmr == TW'(CS_SETUP_CYC - 1)) begin
            r_tmr   <= '0;
            r_sclk  <= 1'b1;
            r_state <= HIGH;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        HIGH: begin
          if (w_phase_end) begin
            // MISO is sampled at the end of the high phase, together with the falling edge.
            r_sclk     <= 1'b0;
            r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
            r_tx_ready <= 1'b0;
            if (!w_last_bit) begin
              r_bit_cnt  <= r_bit_cnt + BW'(1);
              r_mosi     <= r_tx_shift[DATA_WIDTH-2];
              r_tx_shift <= r_tx_shift << 1;
              r_state    <= LOW;
            end else begin
              r_rx_data  <= w_rx_word;
              r_rx_valid <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
              if (r_tx_ready && i_tx_valid) begin
                r_tx_shift <= i_tx_data[DATA_WIDTH-2:0];
                r_mosi     <= i_tx_data[DATA_WIDTH-1];
                r_bit_cnt  <= '0;
                r_state    <= LOW;
              end else begin
                r_tmr   <= '0;
                r_state <= HOLD;
              end
`else
              r_tmr   <= '0;
              r_state <= HOLD;
`endif
            end
          end
`ifdef SPI_MASTER_BURST_EN
          // Registered ready must already be high in the final HIGH cycle.
          else if (w_last_bit && (w_div_cnt == CW'(CLK_DIV - 2))) begin
            r_tx_ready <= 1'b1;
          end
`endif
        end
        LOW: begin
          if (w_phase_end) begin
            r_sclk  <= 1'b1;
            r_state <= HIGH;
          end
        end
        HOLD: begin
          if (r_tmr == TW'(CS_HOLD_CYC - 1)) begin
            r_tmr   <= '0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= GAP;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        GAP: begin
          if (r_tmr == TW'(CS_IDLE_CYC - 1)) begin
            r_tmr      <= '0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = r_busy;
  assign o_sclk     = r_sclk;
  assign o_cs_n     = r_cs_n;
  assign o_mosi     = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with default parameters.
// Loopback or a simple slave responder drives MISO; a negedge monitor checks
// frame timing and pops expected words on every o_rx_valid.
module tb_spi_master;

  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 2;
  localparam int H = 2;
  localparam int G = 4;
  localparam int PERIOD = 1 + S + (2 * W - 1) * D + H + G;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;

  logic         loopback;
  logic [W-1:0] slv_resp;
  logic         slv_bit;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] rx;
    logic [W-1:0] tx;
  } exp_t;
  exp_t exp_q[$];
  logic mq[$];

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : slv_bit;

  spi_master #(
    .DATA_WIDTH   (W),
    .CLK_DIV      (D),
    .CS_SETUP_CYC (S),
    .CS_HOLD_CYC  (H),
    .CS_IDLE_CYC  (G)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .o_busy     (busy),
    .o_sclk     (sclk),
    .o_cs_n     (cs_n),
    .o_mosi     (mosi),
    .i_miso     (miso)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave responder: presents the response MSB first, advancing after each SCLK fall.
  int   sidx = 0;
  logic s_psclk = 1'b0;
  always @(negedge clk) begin
    if (cs_n) sidx = 0;
    else if (s_psclk && !sclk) sidx++;
    s_psclk = sclk;
    slv_bit = (sidx < W) ? slv_resp[W-1-sidx] : 1'b0;
  end

  // Monitor
  int   cyc = 0;
  int   cs_fall_cyc, cs_rise_cyc, rise_cyc, fall_cyc, accept_cyc = -1;
  int   rises = 0, words = 0, last_frame_rises = 0;
  bit   have_gap = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_ready = 1'b0, p_valid = 1'b0;

  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] mw;
    cyc++;
    if (!rst_n) begin
      rises = 0;
      words = 0;
      have_gap = 0;
      accept_cyc = -1;
      mq.delete();
    end else begin
      if (p_ready && p_valid) accept_cyc = cyc - 1;
      if (p_cs && !cs_n) begin
        if (have_gap) chk("cs_idle_min", 32'((cyc - cs_rise_cyc) >= G), 1);
        cs_fall_cyc = cyc;
        rises = 0;
        words = 0;
      end
      if (!p_sclk && sclk) begin
        rises++;
        mq.push_back(mosi);
        chk("cs_low_at_rise", cs_n, 0);
        chk("ready_low_in_frame", tx_ready, 0);
        if (rises == 1) chk("cs_setup", cyc - cs_fall_cyc, S);
        else chk("low_phase", cyc - fall_cyc, D);
        rise_cyc = cyc;
      end
      if (p_sclk && !sclk) begin
        chk("high_phase", cyc - rise_cyc, D);
        fall_cyc = cyc;
      end
      if (rx_valid) begin
        words++;
        chk("rx_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e.rx);
          chk("mosi_bits_avail", 32'(mq.size() >= W), 1);
          if (mq.size() >= W) begin
            for (int i = 0; i < W; i++) mw[W-1-i] = mq.pop_front();
            chk("mosi_word", mw, e.tx);
          end
        end
      end
      if (!p_cs && cs_n) begin
        chk("cs_hold", cyc - fall_cyc, H);
        chk("rises_per_frame", rises, W * words);
        last_frame_rises = rises;
        cs_rise_cyc = cyc;
        have_gap = 1;
      end
`ifndef SPI_MASTER_BURST_EN
      if (!p_ready && tx_ready && accept_cyc >= 0) begin
        chk("word_period", cyc - accept_cyc, PERIOD);
        accept_cyc = -1;
      end
`endif
    end
    p_sclk  = sclk;
    p_cs    = cs_n;
    p_ready = tx_ready;
    p_valid = tx_valid;
  end

  // Raises valid just after a posedge, holds it until accepted, pushes the expectation.
  task automatic send(input logic [W-1:0] w);
    exp_t e;
    bit   ok = 0;
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = w;
    for (int i = 0; i < 500; i++) begin
      if (tx_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      e.tx = w;
      e.rx = loopback ? w : slv_resp;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    tx_data  = W'($urandom);
    chk("accept_in_time", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && tx_ready && !busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_in_time", 32'(ok), 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    loopback = 1'b1;
    slv_resp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", tx_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loopback 0xA5
    send(8'hA5);
    wait_idle();

    // Slave returns 0x3C while master sends 0xFF
    loopback = 1'b0;
    slv_resp = 8'h3C;
    send(8'hFF);
    wait_idle();
    loopback = 1'b1;

    // Back-to-back requests
    send(W'($urandom));
    send(8'h01);
    wait_idle();

    // Requests while busy must be ignored
    send(8'hAA);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (!tx_ready) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
    end
    wait_idle();

    // Random words, random MISO source
    for (int n = 0; n < 6; n++) begin
      loopback = 1'($urandom_range(0, 1));
      slv_resp = W'($urandom);
      send(W'($urandom));
      wait_idle();
    end
    loopback = 1'b1;

    // Reset during bit 4 aborts the word
    send(8'hC3);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (rises >= 4) begin
        ok = 1;
        break;
      end
    end
    chk("reach_bit4", 32'(ok), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_rx_valid", rx_valid, 0);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h96);
    wait_idle();

`ifdef SPI_MASTER_BURST_EN
    // Two words chained in one CS_N frame
    send(8'h12);
    send(8'h34);
    wait_idle();
    chk("burst_rises", last_frame_rises, 2 * W);
`endif

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
